pipelined_cska_adder: RTL and testbench

- Parametrised, pipelined carry-skip adder/subtractor. Successor to the combinational 4-bit-block carry-skip adder.
- Block size, width and pipeline depth are configurable. Adds a subtract mode and valid/ready handshakes on both sides.
- Sits in the datapath wherever a registered N-bit add/sub with backpressure is needed.

---
 rtl/pipelined_cska_adder.sv | 207 ++++++++++++++++++++
 tb/tb_pipelined_cska_adder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cska_adder.sv
// Pipelined carry-skip adder/subtractor with valid/ready handshakes on both sides.
// Each pipeline stage resolves BPS ripple blocks of BLOCK bits; STAGES = N / (BLOCK * BPS).
// N must be a multiple of BLOCK * BPS.
// Optional: define CSKA_SKIP_CNT_EN to add the saturating skip_cnt output that counts
// carry-skip events over all emitted results.
module pipelined_cska_adder #(
  parameter int unsigned N     = 32,
  parameter int unsigned BLOCK = 4,
  parameter int unsigned BPS   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         overflow
`ifdef CSKA_SKIP_CNT_EN
  ,
  output logic [31:0]  skip_cnt
`endif
);

  localparam int unsigned SW     = BLOCK * BPS;
  localparam int unsigned STAGES = N / SW;
  localparam int unsigned IW     = (N > 1) ? $clog2(N) : 1;

  // Stage registers: valid, operands still to be added, accumulated low sum bits, carry.
  logic         valid_q [STAGES];
  logic [N-1:0] opa_q   [STAGES];
  logic [N-1:0] opb_q   [STAGES];
  logic [N-1:0] acc_q   [STAGES];
  logic         carry_q [STAGES];
  logic         ovf_q;

  // Stage inputs: stage 0 takes the ports, stage k takes stage k-1's registers.
  logic         vin     [STAGES];
  logic [N-1:0] sin_a   [STAGES];
  logic [N-1:0] sin_b   [STAGES];
  logic [N-1:0] sin_acc [STAGES];
  logic         sin_c   [STAGES];

  logic [N-1:0] acc_d   [STAGES];
  logic         carry_d [STAGES];
  logic         ovf_d;

  logic [STAGES:0] ready;

  logic [N-1:0]  w_acc;
  logic [IW-1:0] idx;
  logic          c;
  logic          bc;
  logic          p;
  logic          pall;
  logic          r;

`ifdef CSKA_SKIP_CNT_EN
  localparam int unsigned CW = $clog2(N / BLOCK + 1);
  logic [CW-1:0] cnt_q   [STAGES];
  logic [CW-1:0] cnt_d   [STAGES];
  logic [CW-1:0] sin_cnt [STAGES];
  logic [CW-1:0] w_cnt;
  logic [31:0]   skip_cnt_q;
  logic [32:0]   skip_sum;
`endif

  // Backpressure chain: a stage may load when empty or when its successor can load.
  always_comb begin
    r             = out_ready;
    ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      r        = ~valid_q[k] | r;
      ready[k] = r;
    end
    vin[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      vin[k] = valid_q[k-1];
    end
  end

  assign in_ready = ready[0];

  // Per-stage carry-skip evaluation of this stage's slice of bits.
  always_comb begin
    sin_a[0]   = a;
    sin_b[0]   = sub ? ~b : b;
    sin_acc[0] = '0;
    sin_c[0]   = sub | cin;  // subtract forces the +1 of two's complement
`ifdef CSKA_SKIP_CNT_EN
    sin_cnt[0] = '0;
`endif
    for (int k = 1; k < STAGES; k++) begin
      sin_a[k]   = opa_q[k-1];
      sin_b[k]   = opb_q[k-1];
      sin_acc[k] = acc_q[k-1];
      sin_c[k]   = carry_q[k-1];
`ifdef CSKA_SKIP_CNT_EN
      sin_cnt[k] = cnt_q[k-1];
`endif
    end

    ovf_d = 1'b0;
    idx   = '0;
    p     = 1'b0;
    pall  = 1'b0;
    bc    = 1'b0;
    c     = 1'b0;
    w_acc = '0;
`ifdef CSKA_SKIP_CNT_EN
    w_cnt = '0;
`endif
    for (int k = 0; k < STAGES; k++) begin
      w_acc = sin_acc[k];
      c     = sin_c[k];
`ifdef CSKA_SKIP_CNT_EN
      w_cnt = sin_cnt[k];
`endif
      for (int j = 0; j < BPS; j++) begin
        bc   = c;
        pall = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
          idx = IW'(k * SW + j * BLOCK + i);
          p   = sin_a[k][idx] ^ sin_b[k][idx];
          // Remember the carry into the MSB for the signed overflow flag.
          if (idx == IW'(N - 1)) begin
            ovf_d = c;
          end
          w_acc[idx] = p ^ c;
          c          = (sin_a[k][idx] & sin_b[k][idx]) | (p & c);
          pall       = pall & p;
        end
        c = c | (pall & bc);
`ifdef CSKA_SKIP_CNT_EN
        if (pall & bc) begin
          w_cnt = w_cnt + CW'(1);
        end
`endif
      end
      acc_d[k]   = w_acc;
      carry_d[k] = c;
`ifdef CSKA_SKIP_CNT_EN
      cnt_d[k]   = w_cnt;
`endif
    end
    ovf_d = ovf_d ^ carry_d[STAGES-1];
  end

  // Pipeline registers; the last stage doubles as the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        acc_q[k]   <= '0;
        carry_q[k] <= 1'b0;
`ifdef CSKA_SKIP_CNT_EN
        cnt_q[k]   <= '0;
`endif
      end
      ovf_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ready[k]) begin
          valid_q[k] <= vin[k];
          if (vin[k]) begin
            opa_q[k]   <= sin_a[k];
            opb_q[k]   <= sin_b[k];
            acc_q[k]   <= acc_d[k];
            carry_q[k] <= carry_d[k];
`ifdef CSKA_SKIP_CNT_EN
            cnt_q[k]   <= cnt_d[k];
`endif
          end
        end
      end
      if (ready[STAGES-1] && vin[STAGES-1]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign sum       = acc_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign overflow  = ovf_q;

`ifdef CSKA_SKIP_CNT_EN
  assign skip_sum = {1'b0, skip_cnt_q} + 33'(cnt_q[STAGES-1]);

  // Saturating accumulation of skip events for each result taken downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      skip_cnt_q <= '0;
    end else if (out_valid && out_ready) begin
      skip_cnt_q <= skip_sum[32] ? 32'hFFFF_FFFF : skip_sum[31:0];
    end
  end

  assign skip_cnt = skip_cnt_q;
`endif

endmodule

// File: tb/tb_pipelined_cska_adder.sv
// Scoreboard bench for pipelined_cska_adder: the driver pushes reference results on
// every accepted beat, an independent monitor pops and compares on every emitted result.
// Define CSKA_SKIP_CNT_EN to also check skip_cnt.
module tb_pipelined_cska_adder;

  localparam int unsigned N      = 32;
  localparam int unsigned BLOCK  = 4;
  localparam int unsigned STAGES = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         overflow;
`ifdef CSKA_SKIP_CNT_EN
  logic [31:0]  skip_cnt;
`endif

  pipelined_cska_adder #(
    .N     (N),
    .BLOCK (BLOCK),
    .BPS   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
`ifdef CSKA_SKIP_CNT_EN
    ,
    .skip_cnt  (skip_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    int unsigned  skips;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain wide arithmetic; carries into each bit recovered as a ^ b_eff ^ sum.
  function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y,
                                 input logic ci, input logic sb);
    exp_t         e;
    logic [N-1:0] ye;
    logic [N:0]   full;
    logic [N-1:0] cv;
    logic [N-1:0] pv;
    ye     = sb ? ~y : y;
    full   = {1'b0, x} + {1'b0, ye} + {{N{1'b0}}, (sb ? 1'b1 : ci)};
    e.sum  = full[N-1:0];
    e.cout = full[N];
    e.ovf  = (x[N-1] == ye[N-1]) && (e.sum[N-1] != x[N-1]);
    pv     = x ^ ye;
    cv     = pv ^ e.sum;
    e.skips = 0;
    for (int k = 0; k < int'(N / BLOCK); k++) begin
      if (pv[k*BLOCK +: BLOCK] == {BLOCK{1'b1}} && cv[k*BLOCK]) e.skips++;
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [N-1:0] s, input logic c, input logic o,
                              input int unsigned k);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o; e.skips = k;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [N-1:0] ta, input logic [N-1:0] tb,
                       input logic tc, input logic ts, input logic ordy, input exp_t e,
                       output logic acc);
    @(negedge clk);
    in_valid  = v;
    a         = ta;
    b         = tb;
    cin       = tc;
    sub       = ts;
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (acc) sb_q.push_back(e);
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    drive(1'b0, '0, '0, 1'b0, 1'b0, ordy, mk('0, 1'b0, 1'b0, 0), acc);
  endtask

  task automatic rand_beat(input logic v, input logic ordy, output logic acc);
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic         rc;
    logic         rs;
    int unsigned  sel;
    sel = $urandom_range(0, 7);
    ra  = $urandom;
    rb  = $urandom;
    if (sel == 0) ra = '1;
    if (sel == 1) rb = ra;
    if (sel == 2) rb = ~ra;
    rc = 1'($urandom_range(0, 1));
    rs = 1'($urandom_range(0, 1));
    drive(v, ra, rb, rc, rs, ordy, model(ra, rb, rc, rs), acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (sb_q.size() != 0 || out_valid); i++) idle(1'b1);
    check("drain_queue_empty", 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor: compare every emitted result, and hold-stability under backpressure.
  initial begin
    exp_t         e;
    logic         held;
    logic [N-1:0] held_sum;
    logic         held_cout;
    logic         held_ovf;
    longint       exp_skip;
    held     = 1'b0;
    held_sum = '0;
    held_cout = 1'b0;
    held_ovf = 1'b0;
    exp_skip = 0;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        held     = 1'b0;
        exp_skip = 0;
        continue;
      end
`ifdef CSKA_SKIP_CNT_EN
      check("skip_cnt", 64'(skip_cnt), 64'(exp_skip));
`endif
      if (held) begin
        check("hold_out_valid", 64'(out_valid), 64'd1);
        check("hold_sum", 64'(sum), 64'(held_sum));
        check("hold_cout", 64'(cout), 64'(held_cout));
        check("hold_overflow", 64'(overflow), 64'(held_ovf));
      end
      held      = out_valid && !out_ready;
      held_sum  = sum;
      held_cout = cout;
      held_ovf  = overflow;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got sum 0x%0h, required no output", sum);
        end else begin
          e = sb_q.pop_front();
          check("sum", 64'(sum), 64'(e.sum));
          check("cout", 64'(cout), 64'(e.cout));
          check("overflow", 64'(overflow), 64'(e.ovf));
          exp_skip = exp_skip + longint'(e.skips);
          if (exp_skip > 64'hFFFF_FFFF) exp_skip = 64'hFFFF_FFFF;
        end
      end
    end
  end

  // Driver
  initial begin
    logic acc;
    int   lat;
    int   stale;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_sum", 64'(sum), 64'd0);
    check("reset_cout", 64'(cout), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // Carry ripple across all blocks, with latency measurement.
    drive(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, mk(32'h0, 1'b1, 1'b0, 7), acc);
    check("first_accept", 64'(acc), 64'd1);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      idle(1'b1);
      if (out_valid) lat = i;
    end
    check("latency", 64'(lat), 64'(STAGES));
    drain();

    // Signed overflow and subtraction corners, back to back.
    drive(1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, mk(32'h8000_0000, 1'b0, 1'b1, 6), acc);
    drive(1'b1, 32'd5, 32'd7, 1'b1, 1'b1, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 0), acc);
    drive(1'b1, 32'd7, 32'd5, 1'b0, 1'b1, 1'b1, mk(32'd2, 1'b1, 1'b0, 7), acc);
    drain();

    // Streaming: 8 beats back to back, results on consecutive cycles from cycle 4.
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        rand_beat(1'b1, 1'b1, acc);
        check("stream_in_ready", 64'(acc), 64'd1);
      end else begin
        idle(1'b1);
      end
      check("stream_out_valid", 64'(out_valid), 64'((c >= 4) ? 1 : 0));
    end
    drain();

    // Backpressure: fill all stages, stall 3 cycles, then release.
    for (int c = 0; c < 12; c++) begin
      rand_beat(1'b1, !(c >= 4 && c <= 6), acc);
      if (c >= 4 && c <= 6) begin
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
      end else begin
        check("bp_in_ready_high", 64'(in_ready), 64'd1);
      end
    end
    drain();

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      rand_beat($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, acc);
    end
    drain();

    // Reset with three beats in flight.
    for (int c = 0; c < 3; c++) rand_beat(1'b1, 1'b1, acc);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      idle(1'b1);
      if (out_valid) stale++;
    end
    check("midrst_no_stale", 64'(stale), 64'd0);

    // Traffic after the reset still works.
    for (int c = 0; c < 20; c++) rand_beat(1'b1, $urandom_range(0, 3) != 0, acc);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
